// File: rtl/comporta_escalonador.sv
// Floodgate scheduler: grants the single gate to one of four requesters and sequences open/hold/close/recovery.
// Build option COMPORTA_ESC_PRIORIDADE_EN selects fixed priority (index 0 highest) instead of round-robin.
module comporta_escalonador #(
    parameter int W_TEMPO      = 8,
    parameter int T_MIN_ABERTA = 50,
    parameter int T_RECUPERA   = 10,
    parameter int T_MAX_MOV    = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] pedido,
    input  logic       inicioPosicao,
    input  logic       fimPosicao,
    output logic       abrirComporta,
    output logic [3:0] concede,
    output logic       ocupado,
    output logic       erro,
    output logic [3:0] dbEstado
);

    typedef enum logic [3:0] {
        estOcioso   = 4'b0000,
        estArbitra  = 4'b0001,
        estAbrindo  = 4'b0010,
        estAberta   = 4'b0011,
        estFechando = 4'b0100,
        estRecupera = 4'b0101,
        estErro     = 4'b1110
    } estadoT;

    localparam logic [W_TEMPO-1:0] LIM_MOV    = W_TEMPO'(T_MAX_MOV - 1);
    localparam logic [W_TEMPO-1:0] LIM_ABERTA = W_TEMPO'(T_MIN_ABERTA - 1);
    localparam logic [W_TEMPO-1:0] LIM_RECUP  = W_TEMPO'(T_RECUPERA - 1);
    localparam logic [W_TEMPO-1:0] UM         = W_TEMPO'(1);

    estadoT             estado, estadoProx;
    logic [W_TEMPO-1:0] tempo;
    logic [3:0]         concedeProx;
    logic [2:0]         vencedor;
    logic               conta;

    // Returns {found, index}: first set bit of req scanning upward from base, wrapping.
    function automatic logic [2:0] escolhe(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        escolhe = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) escolhe = {1'b1, idx};
        end
    endfunction

`ifdef COMPORTA_ESC_PRIORIDADE_EN
    always_comb vencedor = escolhe(pedido, 2'd0);
`else
    logic [1:0] ultimo, ultimoProx;
    always_comb vencedor = escolhe(pedido, ultimo + 2'd1);
`endif

    always_comb begin
        estadoProx  = estado;
        concedeProx = concede;
`ifndef COMPORTA_ESC_PRIORIDADE_EN
        ultimoProx  = ultimo;
`endif
        case (estado)
            estOcioso: begin
                concedeProx = 4'b0000;
                if (pedido != 4'b0000) estadoProx = estArbitra;
            end
            estArbitra: begin
                if (vencedor[2]) begin
                    concedeProx = 4'b0001 << vencedor[1:0];
`ifndef COMPORTA_ESC_PRIORIDADE_EN
                    ultimoProx  = vencedor[1:0];
`endif
                    estadoProx  = estAbrindo;
                end else begin
                    concedeProx = 4'b0000;
                    estadoProx  = estOcioso;
                end
            end
            estAbrindo: begin
                if (fimPosicao) estadoProx = estAberta;
                else if (tempo == LIM_MOV) begin
                    estadoProx  = estErro;
                    concedeProx = 4'b0000;
                end
            end
            estAberta: begin
                // Only the granted requester can release the gate; others never preempt.
                if (((pedido & concede) == 4'b0000) && (tempo >= LIM_ABERTA))
                    estadoProx = estFechando;
            end
            estFechando: begin
                if (inicioPosicao) begin
                    estadoProx  = estRecupera;
                    concedeProx = 4'b0000;
                end else if (tempo == LIM_MOV) begin
                    estadoProx  = estErro;
                    concedeProx = 4'b0000;
                end
            end
            estRecupera: begin
                concedeProx = 4'b0000;
                if (tempo == LIM_RECUP) estadoProx = estOcioso;
            end
            estErro: concedeProx = 4'b0000;
            default: begin
                estadoProx  = estOcioso;
                concedeProx = 4'b0000;
            end
        endcase
    end

    always_comb conta = (estado == estAbrindo) || (estado == estAberta) ||
                        (estado == estFechando) || (estado == estRecupera);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= estOcioso;
            concede <= 4'b0000;
            tempo   <= '0;
`ifndef COMPORTA_ESC_PRIORIDADE_EN
            ultimo  <= 2'd3;
`endif
        end else begin
            estado  <= estadoProx;
            concede <= concedeProx;
`ifndef COMPORTA_ESC_PRIORIDADE_EN
            ultimo  <= ultimoProx;
`endif
            if (estadoProx != estado) tempo <= '0;
            else if (conta && (tempo != '1)) tempo <= tempo + UM;
        end
    end

    // Status outputs are pure decodes of the state register.
    always_comb begin
        abrirComporta = (estado == estAbrindo) || (estado == estAberta);
        ocupado       = (estado != estOcioso);
        erro          = (estado == estErro);
        case (estado)
            estOcioso, estArbitra, estAbrindo, estAberta,
            estFechando, estRecupera, estErro: dbEstado = estado;
            default:                           dbEstado = 4'b1111;
        endcase
    end

endmodule

// File: tb/tb_comporta_escalonador.sv
// Bench for comporta_escalonador: directed scenarios plus randomized traffic against a cycle reference model.
module tb_comporta_escalonador;

    localparam int TMIN = 4;
    localparam int TREC = 2;
    localparam int TMOV = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pedido = 4'b0000;
    logic       inicioPosicao = 1'b1;
    logic       fimPosicao = 1'b0;
    logic       abrirComporta, ocupado, erro;
    logic [3:0] concede, dbEstado;

    int nComp = 0;
    int nFail = 0;

    // Reference model: phase code, cycles spent in phase, last winner, grant.
    int         mEst = 0;
    int         mTempo = 0;
    int         mUlt = 3;
    logic [3:0] mConc = 4'b0000;

    comporta_escalonador #(
        .W_TEMPO(8), .T_MIN_ABERTA(TMIN), .T_RECUPERA(TREC), .T_MAX_MOV(TMOV)
    ) dut (
        .clock(clock), .reset(reset), .pedido(pedido),
        .inicioPosicao(inicioPosicao), .fimPosicao(fimPosicao),
        .abrirComporta(abrirComporta), .concede(concede), .ocupado(ocupado),
        .erro(erro), .dbEstado(dbEstado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nComp++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic modelStep();
        int  nxt;
        int  idx;
        bit  achou;
        if (reset) begin
            mEst = 0; mTempo = 0; mUlt = 3; mConc = 4'b0000;
            return;
        end
        nxt = mEst;
        case (mEst)
            0: if (pedido != 4'b0000) nxt = 1;
            1: begin
                achou = 1'b0;
                for (int k = 1; k <= 4; k++) begin
`ifdef COMPORTA_ESC_PRIORIDADE_EN
                    idx = k - 1;
`else
                    idx = (mUlt + k) % 4;
`endif
                    if (!achou && pedido[idx]) begin
                        achou = 1'b1;
                        mConc = 4'(1 << idx);
`ifndef COMPORTA_ESC_PRIORIDADE_EN
                        mUlt = idx;
`endif
                    end
                end
                if (achou) nxt = 2;
                else begin nxt = 0; mConc = 4'b0000; end
            end
            2: if (fimPosicao) nxt = 3; else if (mTempo == TMOV - 1) nxt = 14;
            3: if ((pedido & mConc) == 4'b0000 && mTempo >= TMIN - 1) nxt = 4;
            4: if (inicioPosicao) nxt = 5; else if (mTempo == TMOV - 1) nxt = 14;
            5: if (mTempo == TREC - 1) nxt = 0;
            default: nxt = mEst;
        endcase
        if (nxt == 5 || nxt == 14) mConc = 4'b0000;
        if (nxt != mEst) mTempo = 0;
        else if (mEst >= 2 && mEst <= 5 && mTempo < 255) mTempo++;
        mEst = nxt;
    endtask

    task automatic compareAll();
        chk("concede", 32'(concede), 32'(mConc));
        chk("abrirComporta", 32'(abrirComporta), 32'(mEst == 2 || mEst == 3));
        chk("ocupado", 32'(ocupado), 32'(mEst != 0));
        chk("erro", 32'(erro), 32'(mEst == 14));
        chk("dbEstado", 32'(dbEstado), 32'(mEst));
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic waitDb(input logic [3:0] alvo);
        for (int i = 0; i < 100; i++) begin
            if (dbEstado == alvo) break;
            tick();
        end
        chk("espera_estado", 32'(dbEstado), 32'(alvo));
    endtask

    task automatic cicloCompleto(input logic [3:0] req, output logic [3:0] g);
        pedido = req; inicioPosicao = 1'b1; fimPosicao = 1'b0;
        waitDb(4'b0010);
        g = concede;
        inicioPosicao = 1'b0;
        tick(); tick();
        fimPosicao = 1'b1;
        waitDb(4'b0011);
        pedido = req & ~g;
        waitDb(4'b0100);
        fimPosicao = 1'b0;
        tick();
        inicioPosicao = 1'b1;
        waitDb(4'b0000);
        pedido = req;
    endtask

    task automatic doReset();
        reset = 1'b1; pedido = 4'b0000; fimPosicao = 1'b0; inicioPosicao = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] esperado [5];
        int n;

        // Reset state
        doReset();
        chk("reset_db", 32'(dbEstado), 32'h0);
        chk("reset_concede", 32'(concede), 32'h0);
        chk("reset_abrir", 32'(abrirComporta), 32'h0);

        // Grant latency and first opening
        pedido = 4'b0010;
        tick();
        chk("lat_arbitra", 32'(dbEstado), 32'h1);
        tick();
        chk("lat_concede", 32'(concede), 32'h2);
        chk("lat_abrir", 32'(abrirComporta), 32'h1);
        inicioPosicao = 1'b0;
        tick(); tick(); tick();
        fimPosicao = 1'b1;
        tick();
        chk("lat_aberta", 32'(dbEstado), 32'h3);
        pedido = 4'b0000;
        waitDb(4'b0100);
        fimPosicao = 1'b0; inicioPosicao = 1'b1;
        waitDb(4'b0000);

        // Arbitration order with all requesters active
        doReset();
`ifdef COMPORTA_ESC_PRIORIDADE_EN
        esperado = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        esperado = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int i = 0; i < 5; i++) begin
            cicloCompleto(4'b1111, g);
            chk($sformatf("ordem_%0d", i), 32'(g), 32'(esperado[i]));
        end

        // Minimum open time and recovery gap
        doReset();
        pedido = 4'b0001; inicioPosicao = 1'b1;
        waitDb(4'b0010);
        inicioPosicao = 1'b0; fimPosicao = 1'b1;
        waitDb(4'b0011);
        n = 1;
        tick();
        if (dbEstado == 4'b0011) n++;
        pedido = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dbEstado != 4'b0011) break;
            n++;
        end
        chk("min_aberta_ciclos", 32'(n), 32'(TMIN));
        chk("min_aberta_fechando", 32'(dbEstado), 32'h4);
        chk("min_aberta_abrir0", 32'(abrirComporta), 32'h0);
        fimPosicao = 1'b0; inicioPosicao = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (dbEstado != 4'b0101) break;
            n++;
            tick();
        end
        chk("recupera_ciclos", 32'(n), 32'(TREC));
        chk("recupera_ocioso", 32'(dbEstado), 32'h0);

        // Movement timeout while opening
        pedido = 4'b0001; inicioPosicao = 1'b1; fimPosicao = 1'b0;
        waitDb(4'b0010);
        inicioPosicao = 1'b0;
        n = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (dbEstado != 4'b0010) break;
            n++;
        end
        chk("timeout_ciclos", 32'(n), 32'(TMOV));
        chk("timeout_db", 32'(dbEstado), 32'he);
        chk("timeout_erro", 32'(erro), 32'h1);
        chk("timeout_abrir", 32'(abrirComporta), 32'h0);
        for (int i = 0; i < 10; i++) begin
            pedido = 4'($urandom_range(0, 15));
            fimPosicao = 1'($urandom_range(0, 1));
            tick();
        end
        chk("erro_pegajoso", 32'(dbEstado), 32'he);

        // fimPosicao on the last allowed cycle wins over the timeout
        doReset();
        pedido = 4'b0001;
        waitDb(4'b0010);
        inicioPosicao = 1'b0;
        repeat (TMOV - 1) tick();
        fimPosicao = 1'b1;
        tick();
        chk("simult_aberta", 32'(dbEstado), 32'h3);
        chk("simult_erro", 32'(erro), 32'h0);

        // Reset while open
        reset = 1'b1;
        tick();
        chk("rst_meio_abrir", 32'(abrirComporta), 32'h0);
        chk("rst_meio_concede", 32'(concede), 32'h0);
        chk("rst_meio_db", 32'(dbEstado), 32'h0);
        reset = 1'b0; fimPosicao = 1'b0; inicioPosicao = 1'b1;
        pedido = 4'b1111;
        tick(); tick();
        chk("rst_meio_grant", 32'(concede), 32'h1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) pedido = 4'($urandom_range(0, 15));
            fimPosicao = ($urandom_range(0, 4) == 0);
            inicioPosicao = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
